aes_core_scheduler: RTL and testbench

- Shares one AES-128 core (start/valid interface, as aes_decryptor_top) among NREQ requesters.
- Round-robin arbitration; latches the winning key and data block, pulses core start, and waits for core valid with a watchdog.
- Returns the result to the granted requester over a valid/ready handshake.
- Sits between the host-side request ports and the single AES core instance.

---
 rtl/aes_core_scheduler.sv | 110 +++++++++++
 tb/tb_aes_core_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_scheduler.sv
// Round-robin front end sharing one AES-128 core among NREQ requesters.
// Latches the winner's key/block, pulses core_start, waits for core_valid under a watchdog, returns the result.
module aes_core_scheduler #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*128-1:0]  req_key,
  input  logic [NREQ*128-1:0]  req_data,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [127:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 core_start,
  output logic [127:0]         core_key,
  output logic [127:0]         core_din,
  input  logic                 core_valid,
  input  logic [127:0]         core_dout
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [GW-1:0] grant, last_grant, pick, cand;
  logic          pick_ok;
  logic [WW-1:0] wdog;
  logic [127:0]  keys [NREQ];
  logic [127:0]  blks [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign keys[g] = req_key[128*g +: 128];
    assign blks[g] = req_data[128*g +: 128];
  end

  // Walk candidates starting just after the last grant, wrapping at NREQ-1.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = last_grant;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == GW'(NREQ-1)) ? '0 : cand + 1'b1;
      if (!pick_ok && req_valid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && pick_ok) req_ready[pick] = 1'b1;
  end

  assign core_start = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NREQ-1);
      wdog       <= '0;
      core_key   <= '0;
      core_din   <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rsp_valid  <= '0;
    end else begin
      case (state)
        IDLE: if (pick_ok) begin
          grant    <= pick;
          core_key <= keys[pick];
          core_din <= blks[pick];
          state    <= ISSUE;
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // core_valid takes priority over a simultaneous watchdog expiry
          if (core_valid) begin
            rsp_data         <= core_dout;
            rsp_err          <= 1'b0;
            rsp_valid[grant] <= 1'b1;
            state            <= RESP;
          end else if (wdog == WW'(TIMEOUT-2)) begin
            rsp_data         <= '0;
            rsp_err          <= 1'b1;
            rsp_valid[grant] <= 1'b1;
            state            <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: if (rsp_ready[grant]) begin
          last_grant <= grant;
          rsp_valid  <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_core_scheduler.sv
// Bench for aes_core_scheduler: stub AES core with programmable latency/hang, round-robin reference model.
module tb_aes_core_scheduler;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*128-1:0] req_key, req_data;
  logic [127:0]        rsp_data, core_key, core_din, core_dout;
  logic                rsp_err, core_start, core_valid;

  int checks = 0;
  int errors = 0;
  int last   = NREQ-1;
  int core_lat = 2;
  bit core_hang = 1'b0;
  int cnt;
  int starts = 0;
  logic [127:0] kk [NREQ];
  logic [127:0] dd [NREQ];

  always #5 clk = ~clk;

  aes_core_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_key(core_key), .core_din(core_din),
    .core_valid(core_valid), .core_dout(core_dout)
  );

  function automatic logic [127:0] ref_f(input logic [127:0] k, input logic [127:0] d);
    return k ^ {d[63:0], d[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Next requester by round-robin rule: first pending index after the last served one.
  function automatic int rr_pick(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Stub core: pulses core_valid core_lat+1 cycles after the start edge, or never when hung.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= -1;
      core_valid <= 1'b0;
      core_dout  <= '0;
    end else begin
      core_valid <= 1'b0;
      if (core_start) cnt <= core_hang ? -1 : core_lat;
      else if (cnt == 0) begin
        core_valid <= 1'b1;
        core_dout  <= ref_f(core_key, core_din);
        cnt        <= -1;
      end else if (cnt > 0) cnt <= cnt - 1;
    end
  end

  always @(posedge clk) if (core_start) starts <= starts + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL req_ready_onehot got %b required at most one bit", req_ready);
      end
    end
  end

  task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] d);
    kk[i] = k;
    dd[i] = d;
    req_key[128*i +: 128]  = k;
    req_data[128*i +: 128] = d;
  endtask

  task automatic wait_accept(output int idx);
    idx = -1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        break;
      end
      @(negedge clk);
    end
    if (idx < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout req_ready %b required a grant within 100 cycles", req_ready);
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid == '0 && cyc < TIMEOUT + 20) begin
      @(negedge clk);
      cyc++;
    end
    if (rsp_valid == '0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout rsp_valid stayed %b", rsp_valid);
    end
  endtask

  task automatic handshake(input int g);
    rsp_ready = '0;
    if (g >= 0) rsp_ready[g] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    if (g >= 0) last = g;
  endtask

  // One complete job: random operands, grant checked against the model, response checked.
  task automatic run_job(input logic [NREQ-1:0] mask, input int lat, input bit hang, output int idx);
    int exp_idx, cyc;
    logic [127:0] exp;
    logic [NREQ-1:0] oh;
    for (int i = 0; i < NREQ; i++) set_req(i, rand128(), rand128());
    core_lat = lat;
    core_hang = hang;
    req_valid = mask;
    exp_idx = rr_pick(mask);
    wait_accept(idx);
    checks++;
    if (idx !== exp_idx) begin
      errors++;
      $display("FAIL grant got %0d required %0d (mask %b)", idx, exp_idx, mask);
    end
    oh = '0;
    exp = '0;
    if (idx >= 0) begin
      oh[idx] = 1'b1;
      exp = ref_f(kk[idx], dd[idx]);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("FAIL issue_start core_start %b required 1", core_start);
    end
    wait_rsp(cyc);
    checks++;
    if (hang) begin
      if (cyc != TIMEOUT || rsp_valid !== oh || rsp_err !== 1'b1 || rsp_data !== '0) begin
        errors++;
        $display("FAIL timeout_rsp lat %0d valid %b err %b data %h required lat %0d valid %b err 1 data 0",
                 cyc, rsp_valid, rsp_err, rsp_data, TIMEOUT, oh);
      end
    end else begin
      if (cyc != lat + 3 || rsp_valid !== oh || rsp_err !== 1'b0 || rsp_data !== exp) begin
        errors++;
        $display("FAIL job_rsp lat %0d valid %b err %b data %h required lat %0d valid %b err 0 data %h",
                 cyc, rsp_valid, rsp_err, rsp_data, lat + 3, oh, exp);
      end
    end
    handshake(idx);
  endtask

  task automatic test_reset;
    req_valid = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 ||
        core_start !== 1'b0 || core_key !== '0 || core_din !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready %b valid %b data %h err %b start %b key %h din %h required all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_key, core_din);
    end
    req_valid = '0;
    rst_n = 1'b1;
    last = NREQ-1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || core_start !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL post_reset_idle valid %b start %b ready %b required 0", rsp_valid, core_start, req_ready);
    end
  endtask

  task automatic test_single;
    int idx, s0, cyc;
    logic [127:0] k, d, exp;
    k = 128'h000102030405060708090A0B0C0D0E0F;
    d = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    set_req(0, k, d);
    set_req(1, rand128(), rand128());
    exp = ref_f(k, d);
    core_lat = 2;
    core_hang = 1'b0;
    s0 = starts;
    req_valid = 2'b01;
    wait_accept(idx);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b required 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start got %b required 1", core_start);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 1'b0 || core_key !== k || core_din !== d) begin
      errors++;
      $display("FAIL single_core_if start %b key %h din %h required 0 %h %h", core_start, core_key, core_din, k, d);
    end
    cyc = 0;
    while (core_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL single_early_rsp got %b required 00", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== exp || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp valid %b data %h err %b required 01 %h 0", rsp_valid, rsp_data, rsp_err, exp);
    end
    handshake(0);
    checks++;
    if (starts - s0 != 1 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL single_done starts %0d valid %b required 1 start and 00", starts - s0, rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    int idx;
    logic [NREQ-1:0] m;
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    last = NREQ-1;
    for (int j = 0; j < 6; j++) begin
      run_job('1, $urandom_range(0, 6), 1'b0, idx);
      checks++;
      if (idx != j % NREQ) begin
        errors++;
        $display("FAIL rr_order job %0d got %0d required %0d", j, idx, j % NREQ);
      end
    end
    for (int j = 0; j < 10; j++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_job(m, $urandom_range(0, 5), 1'b0, idx);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    int g, idx, cyc;
    logic [NREQ-1:0] oh;
    logic [127:0] d;
    for (int i = 0; i < NREQ; i++) set_req(i, rand128(), rand128());
    core_lat = 1;
    core_hang = 1'b0;
    req_valid = '1;
    g = rr_pick('1);
    oh = '0;
    oh[g] = 1'b1;
    wait_accept(idx);
    @(negedge clk);
    wait_rsp(cyc);
    d = rsp_data;
    checks++;
    if (idx != g || rsp_valid !== oh || d !== ref_f(kk[g], dd[g])) begin
      errors++;
      $display("FAIL bp_first grant %0d valid %b data %h required %0d %b %h", idx, rsp_valid, d, g, oh, ref_f(kk[g], dd[g]));
    end
    rsp_ready = ~oh;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== oh || rsp_data !== d || rsp_err !== 1'b0 || req_ready !== '0 || core_start !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d valid %b data %h ready %b start %b required %b %h 00 0",
                 c, rsp_valid, rsp_data, req_ready, core_start, oh, d);
      end
    end
    handshake(g);
    checks++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL bp_release valid %b required 00", rsp_valid);
    end
    run_job('1, 1, 1'b0, idx);
    req_valid = '0;
  endtask

  task automatic test_timeout;
    int idx;
    run_job('1, 0, 1'b1, idx);
    run_job('1, 3, 1'b0, idx);
    req_valid = '0;
  endtask

  task automatic test_reset_wait;
    int idx;
    logic [NREQ-1:0] m;
    set_req(0, rand128(), rand128());
    core_hang = 1'b1;
    req_valid = '0;
    req_valid[0] = 1'b1;
    wait_accept(idx);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 ||
        core_start !== 1'b0 || core_key !== '0 || core_din !== '0) begin
      errors++;
      $display("FAIL wait_reset ready %b valid %b data %h err %b start %b key %h din %h required all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_key, core_din);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last = NREQ-1;
    core_hang = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || core_start !== 1'b0) begin
        errors++;
        $display("FAIL stale_rsp valid %b start %b required 00 0", rsp_valid, core_start);
      end
    end
    m = '0;
    m[1] = 1'b1;
    run_job(m, 2, 1'b0, idx);
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = '0;
    req_key   = '0;
    req_data  = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_reset_wait;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
